sram_2rw_bm: RTL

- Parametrised behavioural dual-port (2RW) synchronous SRAM with per-byte write masks, built for the RISC-V core's register-file and scratch memories.
- Successor to the fixed-size byte-masked 2RW macros: depth, width and byte-lane count are generic, and read latency is configurable.
- Adds a post-reset zero-fill sequencer and same-cycle write-collision arbitration with a flag.
- One clock for both ports.

---
 rtl/sram_2rw_bm.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sram_2rw_bm.sv
// Behavioural 2RW byte-masked SRAM with post-reset zero fill and write/write arbitration.
// Define SRAM_WR_FWD_EN to forward same-address cross-port write data to the reader.
module sram_2rw_bm #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int BYTE_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic                       CE,
  input  logic                       RSTB,
  input  logic [ADDR_W-1:0]          A1,
  input  logic [ADDR_W-1:0]          A2,
  input  logic                       CSB1,
  input  logic                       CSB2,
  input  logic                       WEB1,
  input  logic                       WEB2,
  input  logic                       OEB1,
  input  logic                       OEB2,
  input  logic [DATA_W/BYTE_W-1:0]   BYTEMASK1,
  input  logic [DATA_W/BYTE_W-1:0]   BYTEMASK2,
  input  logic [DATA_W-1:0]          I1,
  input  logic [DATA_W-1:0]          I2,
  output logic [DATA_W-1:0]          O1,
  output logic [DATA_W-1:0]          O2,
  output logic                       READY,
  output logic                       COLLISION
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int LANES = DATA_W / BYTE_W;

  if (DATA_W % BYTE_W != 0) begin : g_bad_width
    $error("DATA_W must be a multiple of BYTE_W");
  end
  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("READ_LAT must be 1 or 2");
  end

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] fill_cnt, fill_nx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run, same;
  logic              we1, we2, re1, re2;
  logic [LANES-1:0]  lw1, lw2;
  logic [DATA_W-1:0] bm1, bm2, bx1, bx2;
  logic [DATA_W-1:0] wd1, wd2, rd1, rd2;
  logic [DATA_W-1:0] q1, q2, o1_d, o2_d;
  logic              ready_q, coll_q;

  assign run  = state == RUN;
  assign same = A1 == A2;
  assign we1  = run & ~CSB1 & ~WEB1;
  assign we2  = run & ~CSB2 & ~WEB2;
  assign re1  = run & ~CSB1 & WEB1;
  assign re2  = run & ~CSB2 & WEB2;

  // Port 1 owns overlapping lanes, so port 2 loses them up front.
  assign lw1 = we1 ? BYTEMASK1 : '0;
  assign lw2 = (we2 ? BYTEMASK2 : '0) & ~(same ? lw1 : '0);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign bm1[k*BYTE_W +: BYTE_W] = {BYTE_W{lw1[k]}};
    assign bm2[k*BYTE_W +: BYTE_W] = {BYTE_W{lw2[k]}};
  end

  assign bx1 = same ? bm1 : '0;
  assign bx2 = same ? bm2 : '0;

  assign wd1 = (mem[A1] & ~bm1 & ~bx2) | (I1 & bm1) | (I2 & bx2);
  assign wd2 = (mem[A2] & ~bm2) | (I2 & bm2);

`ifdef SRAM_WR_FWD_EN
  assign rd1 = (mem[A1] & ~bx2) | (I2 & bx2);
  assign rd2 = (mem[A2] & ~bx1) | (I1 & bx1);
`else
  assign rd1 = mem[A1];
  assign rd2 = mem[A2];
`endif

  always_comb begin
    state_nx = state;
    fill_nx  = fill_cnt;
    unique case (state)
      INIT: begin
        fill_nx = fill_cnt + 1'b1;
        if (fill_cnt == '1) state_nx = RUN;
      end
      RUN: ;
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge CE or negedge RSTB) begin
    if (!RSTB) begin
      state    <= INIT;
      fill_cnt <= '0;
      ready_q  <= 1'b0;
      coll_q   <= 1'b0;
      q1       <= '0;
      q2       <= '0;
    end else begin
      state    <= state_nx;
      fill_cnt <= fill_nx;
      ready_q  <= run;
      coll_q   <= we1 & we2 & same & |(BYTEMASK1 & BYTEMASK2);
      if (re1) q1 <= rd1;
      if (re2) q2 <= rd2;
    end
  end

  // Array has no reset; the fill sequencer clears it instead.
  always_ff @(posedge CE) begin
    if (!run) begin
      if (RSTB) mem[fill_cnt] <= '0;
    end else begin
      if (|lw2) mem[A2] <= wd2;
      if (|lw1) mem[A1] <= wd1;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] p1, p2;
    always_ff @(posedge CE or negedge RSTB) begin
      if (!RSTB) begin
        p1 <= '0;
        p2 <= '0;
      end else begin
        p1 <= q1;
        p2 <= q2;
      end
    end
    assign o1_d = p1;
    assign o2_d = p2;
  end else begin : g_lat1
    assign o1_d = q1;
    assign o2_d = q2;
  end

  assign O1        = OEB1 ? '0 : o1_d;
  assign O2        = OEB2 ? '0 : o2_d;
  assign READY     = ready_q;
  assign COLLISION = coll_q;

endmodule
